instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch sequencer: the producer side of the instruction-register interface. Holds the program counter, fetches 16-bit instruction words from instruction memory over a request/acknowledge handshake, and presents each word on `instruction` with a one-cycle `irload` strobe. The IR decoder consumes that strobe and splits the word into opcode[15:12], dreg[11:8], sreg[7:4], treg[3:0] and address[7:0]. The unit then waits for the execute stage to finish before fetching the next word, and accepts branch/jump targets.

## Interface
- `ADDR_W`, 8, program counter / memory address width
- `DATA_W`, 16, instruction word width
- `RESET_PC`, 8'h00, PC value after reset

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `mem_req`  out  1  fetch request to instruction memory
- `mem_addr`  out  ADDR_W  fetch address; stable while `mem_req`=1
- `mem_ack`  in  1  memory has valid `mem_rdata` this cycle
- `mem_rdata`  in  DATA_W  instruction word from memory
- `instruction`  out  DATA_W  registered instruction presented to IR decoder
- `irload`  out  1  one-cycle strobe: `instruction` is new
- `exec_done`  in  1  execute stage finished current instruction
- `pc_load`  in  1  load `pc_target` into PC (branch/jump)
- `pc_target`  in  ADDR_W  branch/jump destination
- `halt`  in  1  stop fetching after current instruction
- `pc`  out  ADDR_W  current program counter
- `busy`  out  1  high in any state other than IDLE

## Operation
- Reset, asynchronous on `rst_n`=0:
  - state=IDLE, `pc`=RESET_PC, `instruction`=0
  - `irload`=0, `mem_req`=0, `mem_addr`=0, `busy`=0
- States: IDLE, REQ, LOAD, EXEC.
- IDLE: if `halt`=0, go to REQ next cycle; otherwise remain in IDLE.
- REQ:
  - `mem_req`=1, `mem_addr`=`pc`, held until `mem_ack`.
  - On `mem_ack`: `instruction`<=`mem_rdata`, `pc`<=`pc`+1 (mod 2^ADDR_W, so 8'hFF wraps to 8'h00), go to LOAD.
  - `mem_ack` while not in REQ is ignored.
- LOAD: `irload`=1 for exactly this cycle, then go to EXEC.
- EXEC:
  - `instruction` is held.
  - `pc_load`=1 sets `pc`<=`pc_target`. This overrides the increment already applied; the last pc_load seen wins.
  - On `exec_done`: go to IDLE if `halt`=1, else to REQ.
  - `pc_load` and `exec_done` in the same cycle: the target is used for the very next fetch.
- `pc_load` outside EXEC is ignored. No in-flight fetch is cancelled.
- `halt` is sampled only in IDLE and at `exec_done`. A halt raised during REQ/LOAD takes effect after the current instruction completes.
- Reset mid-REQ: `mem_req` drops immediately (asynchronously). A late `mem_ack` after reset is ignored.

## Timing
- IDLE→REQ: `mem_req` rises 1 cycle after `halt` is low in IDLE.
- `mem_ack` in cycle N → `instruction` valid and `irload`=1 in cycle N+1; `pc` shows the incremented value from N+1.
- Minimum cycles per instruction with zero-wait memory and immediate `exec_done`: REQ 1 + LOAD 1 + EXEC 1 = 3.
- `irload` is never high for two consecutive cycles.
- `instruction` changes only on the clock edge that enters LOAD.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `cpu_pkg`:
  - `ADDR_W`, `DATA_W`
  - field-position constants for opcode [15:12], dreg [11:8], sreg [7:4], treg [3:0], address [7:0]
  - fetch-state enum `fetch_state_t`
- One sub-module, `pc_counter`:
  - ADDR_W register with reset value, increment enable, and load with priority over increment.
  - Instantiated once.
- FSM and instruction register live in the top module.

## Test plan
- Reset, memory with 0-wait ack, words 16'h1234, 16'h2ABC at addresses 0,1, `exec_done` 1 cycle after `irload`:
  - `mem_addr` 0 then 1
  - `instruction`=16'h1234 then 16'h2ABC, each with a single `irload` pulse
  - 3 cycles per instruction
- Memory ack delayed 4 cycles:
  - `mem_req`/`mem_addr` held constant for all 4 cycles
  - `irload` 1 cycle after ack
- `pc_load`=1 with `pc_target`=8'h40 in EXEC, same cycle as `exec_done`: next `mem_addr`=8'h40, and `pc`=8'h41 after that fetch.
- PC wrap: `RESET_PC`=8'hFF, fetch one word → `pc`=8'h00 and next `mem_addr`=8'h00.
- `halt`=1 raised during REQ: the current instruction completes with its `irload`, then the unit goes to IDLE (`busy`=0). Lowering `halt` resumes at the next sequential address.
- `rst_n` pulsed low mid-REQ:
  - `mem_req`=0 immediately, `pc`=RESET_PC
  - an ack arriving during reset produces no `irload`

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths, instruction field positions and the
// fetch sequencer state type.
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    localparam int OPCODE_MSB  = 15;
    localparam int OPCODE_LSB  = 12;
    localparam int DREG_MSB    = 11;
    localparam int DREG_LSB    = 8;
    localparam int SREG_MSB    = 7;
    localparam int SREG_LSB    = 4;
    localparam int TREG_MSB    = 3;
    localparam int TREG_LSB    = 0;
    localparam int ADDRESS_MSB = 7;
    localparam int ADDRESS_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        LOAD,
        EXEC
    } fetch_state_t;

    function automatic logic [3:0] opcode_of(input logic [DATA_W-1:0] w);
        return w[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory handshake plus the IR / execute-stage
// handoff signals of the fetch sequencer.
interface instr_fetch_unit_if;
    import cpu_pkg::*;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] instruction;
    logic              irload;
    logic              exec_done;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;
    logic              halt;
    logic [ADDR_W-1:0] pc;
    logic              busy;

    modport master (
        output mem_req, mem_addr, instruction, irload, pc, busy,
        input  mem_ack, mem_rdata, exec_done, pc_load, pc_target, halt
    );

    modport slave (
        input  mem_req, mem_addr, instruction, irload, pc, busy,
        output mem_ack, mem_rdata, exec_done, pc_load, pc_target, halt
    );

endinterface

// File: rtl/instr_fetch_unit_pc_counter.sv
// pc_counter: program counter register; a load takes priority over an increment,
// and o_pc_next exposes the value the register takes on the coming edge.
module pc_counter
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_inc,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_target,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_next
);

    logic [ADDR_W-1:0] r_pc;

    always_comb o_pc_next = i_load ? i_target : i_inc ? r_pc + 1'b1 : r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pc <= RESET_PC;
        else        r_pc <= o_pc_next;
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch sequencer that requests words from instruction memory,
// presents them to the IR with a one-cycle irload strobe and waits for execute.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input logic                clk,
    input logic                rst_n,
    instr_fetch_unit_if.master bus
);

    fetch_state_t      r_state;
    logic              r_mem_req;
    logic              r_irload;
    logic              r_busy;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_instruction;
    logic              w_inc;
    logic              w_load;
    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_pc_next;

    assign w_inc  = (r_state == REQ) && bus.mem_ack;
    assign w_load = (r_state == EXEC) && bus.pc_load;

    pc_counter #(.RESET_PC(RESET_PC)) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_inc    (w_inc),
        .i_load   (w_load),
        .i_target (bus.pc_target),
        .o_pc     (w_pc),
        .o_pc_next(w_pc_next)
    );

    // Leaving EXEC uses w_pc_next so a same-cycle pc_load steers the next fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_irload      <= 1'b0;
            r_busy        <= 1'b0;
            r_instruction <= '0;
        end else begin
            r_irload <= 1'b0;
            case (r_state)
                IDLE: if (!bus.halt) begin
                    r_state    <= REQ;
                    r_mem_req  <= 1'b1;
                    r_mem_addr <= w_pc;
                    r_busy     <= 1'b1;
                end
                REQ: if (bus.mem_ack) begin
                    r_state       <= LOAD;
                    r_mem_req     <= 1'b0;
                    r_irload      <= 1'b1;
                    r_instruction <= bus.mem_rdata;
                end
                LOAD: r_state <= EXEC;
                EXEC: if (bus.exec_done) begin
                    r_state    <= bus.halt ? IDLE : REQ;
                    r_mem_req  <= !bus.halt;
                    r_busy     <= !bus.halt;
                    r_mem_addr <= w_pc_next;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req     = r_mem_req;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.instruction = r_instruction;
    assign bus.irload      = r_irload;
    assign bus.busy        = r_busy;
    assign bus.pc          = w_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized memory/execute responders feed a scoreboard
// whose expected fetches come from a next-address model of the program counter.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] pc_after;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus ();
    instr_fetch_unit_if bus2 ();

    instr_fetch_unit #(.RESET_PC(8'h00)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
    instr_fetch_unit #(.RESET_PC(8'hFF)) dut_wrap (.clk(clk), .rst_n(rst_n), .bus(bus2.master));

    logic [DATA_W-1:0] mem [256];
    exp_t              sb [$];
    logic [ADDR_W-1:0] exp_addr;
    int total = 0, bad = 0, cyc = 0, last_ack = -10, n_irl = 0;
    int lat_lo = 0, lat_hi = 0, ex_lo = 0, ex_hi = 0, pl_pct = 0;
    bit pl_fixed = 0, force_ack = 0;
    logic [ADDR_W-1:0] pl_tgt = 8'h40;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_irload(input string name);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.irload && n < 100);
        check(name, bus.irload, 1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 60) begin @(negedge clk); n++; end
        check(name, bus.busy, 0);
    endtask

    // Memory: random wait states, data looked up at the DUT's address; the
    // expectation comes from the model's own next-fetch address.
    initial begin : mem_model
        int wait_cnt;
        bit prev_req;
        logic [ADDR_W-1:0] prev_addr;
        wait_cnt = 0; prev_req = 0; prev_addr = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus.mem_ack = force_ack;
            if (rst_n && bus.mem_req) begin
                if (!prev_req) wait_cnt = $urandom_range(lat_hi, lat_lo);
                else check("mem_addr_stable", bus.mem_addr, prev_addr);
                if (wait_cnt == 0) begin
                    check("mem_addr", bus.mem_addr, exp_addr);
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = mem[bus.mem_addr];
                    sb.push_back('{exp_addr, mem[exp_addr], ADDR_W'(exp_addr + 1)});
                    last_ack = cyc;
                    exp_addr = ADDR_W'(exp_addr + 1);
                    wait_cnt = -1;
                end else wait_cnt--;
            end
            prev_req = rst_n && bus.mem_req;
            prev_addr = bus.mem_addr;
        end
    end

    // Execute stage: random duration, random branches; junk pc_load outside EXEC.
    initial begin : exec_model
        int cnt;
        bit in_exec;
        cnt = 0; in_exec = 0;
        bus.exec_done = 1'b0; bus.pc_load = 1'b0; bus.pc_target = '0;
        forever begin
            @(posedge clk); #1;
            bus.exec_done = 1'b0;
            bus.pc_load = $urandom_range(99) < pl_pct;
            bus.pc_target = pl_fixed ? pl_tgt : ADDR_W'($urandom);
            if (!rst_n) in_exec = 0;
            else if (in_exec) begin
                if (bus.pc_load) exp_addr = bus.pc_target;
                if (cnt == 0) begin bus.exec_done = 1'b1; in_exec = 0; end
                else cnt--;
            end else if (bus.irload) begin
                in_exec = 1;
                cnt = $urandom_range(ex_hi, ex_lo);
            end
        end
    end

    initial begin : monitor
        bit prev_irl;
        exp_t e;
        prev_irl = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.irload) begin
                    n_irl++;
                    check("irload_single", prev_irl, 0);
                    check("sb_depth", sb.size(), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("instruction", bus.instruction, e.data);
                        check("pc_after_fetch", bus.pc, e.pc_after);
                        check("ack_to_irload", cyc - last_ack, 1);
                    end
                end
                if (bus.mem_req || bus.irload) check("busy", bus.busy, 1);
            end
            prev_irl = rst_n && bus.irload;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n, t, seen, start;
        logic [ADDR_W-1:0] saved;
        for (int i = 0; i < 256; i++) mem[i] = DATA_W'($urandom);
        mem[0] = 16'h1234;
        mem[1] = 16'h2ABC;
        exp_addr = 8'h00;
        bus.halt = 1'b0;
        bus2.halt = 1'b1; bus2.mem_ack = 1'b0; bus2.mem_rdata = '0;
        bus2.exec_done = 1'b0; bus2.pc_load = 1'b0; bus2.pc_target = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_irload", bus.irload, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_pc", bus.pc, 8'h00);
        check("rst_instruction", bus.instruction, 0);
        check("rst_pc_wrap_dut", bus2.pc, 8'hFF);
        rst_n = 1'b1;

        // Back-to-back zero-wait fetches: 3 cycles per instruction.
        wait_irload("irload_first");
        check("instr_first", bus.instruction, 16'h1234);
        t = cyc;
        wait_irload("irload_second");
        check("instr_second", bus.instruction, 16'h2ABC);
        check("cycles_per_instr", cyc - t, 3);
        bus.halt = 1'b1;
        wait_idle("idle_after_seq");

        // 4 wait states with halt raised during REQ.
        lat_lo = 4; lat_hi = 4;
        bus.halt = 1'b0;
        n = 0;
        while (!bus.mem_req && n < 20) begin @(negedge clk); n++; end
        bus.halt = 1'b1;
        n = 0;
        while (bus.mem_req && n < 20) begin @(negedge clk); n++; end
        check("req_hold_cycles", n, 5);
        check("irload_after_halt_req", bus.irload, 1);
        wait_idle("idle_after_halt");
        check("pc_halted", bus.pc, exp_addr);
        saved = bus.pc;
        seen = 0;
        repeat (5) begin @(negedge clk); seen = seen | bus.mem_req; end
        check("halted_no_req", seen, 0);
        bus.halt = 1'b0;
        n = 0;
        while (!bus.mem_req && n < 20) begin @(negedge clk); n++; end
        check("resume_addr", bus.mem_addr, saved);
        bus.halt = 1'b1;
        wait_idle("idle_after_resume");

        // Branch in the same cycle as exec_done.
        lat_lo = 0; lat_hi = 0; pl_pct = 100; pl_fixed = 1; pl_tgt = 8'h40;
        bus.halt = 1'b0;
        wait_irload("irload_pre_branch");
        wait_irload("irload_branch");
        check("branch_instr", bus.instruction, mem[8'h40]);
        check("branch_pc", bus.pc, 8'h41);
        bus.halt = 1'b1;
        wait_idle("idle_after_branch");
        pl_pct = 0; pl_fixed = 0;

        // PC wrap on the RESET_PC=FF instance, driven by hand.
        bus2.halt = 1'b0;
        n = 0;
        while (!bus2.mem_req && n < 20) begin @(negedge clk); n++; end
        check("wrap_first_addr", bus2.mem_addr, 8'hFF);
        bus2.mem_ack = 1'b1; bus2.mem_rdata = 16'hBEEF;
        @(negedge clk);
        bus2.mem_ack = 1'b0;
        check("wrap_irload", bus2.irload, 1);
        check("wrap_instr", bus2.instruction, 16'hBEEF);
        check("wrap_pc", bus2.pc, 8'h00);
        @(negedge clk);
        bus2.exec_done = 1'b1;
        @(negedge clk);
        bus2.exec_done = 1'b0;
        bus2.halt = 1'b1;
        check("wrap_next_req", bus2.mem_req, 1);
        check("wrap_next_addr", bus2.mem_addr, 8'h00);

        // Randomized traffic.
        lat_lo = 0; lat_hi = 3; ex_lo = 0; ex_hi = 3; pl_pct = 20;
        start = n_irl;
        bus.halt = 1'b0;
        repeat (500) begin
            @(negedge clk);
            if ($urandom_range(99) < 4) bus.halt = ~bus.halt;
        end
        bus.halt = 1'b1;
        wait_idle("idle_after_random");
        check("random_progress", n_irl - start > 20, 1);
        pl_pct = 0; ex_hi = 0;

        // Reset in the middle of a long REQ, with an ack during reset.
        lat_lo = 6; lat_hi = 6;
        bus.halt = 1'b0;
        n = 0;
        while (!bus.mem_req && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_mem_req", bus.mem_req, 0);
        check("async_rst_pc", bus.pc, 8'h00);
        check("async_rst_busy", bus.busy, 0);
        sb.delete();
        exp_addr = 8'h00;
        bus.halt = 1'b1;
        force_ack = 1;
        repeat (3) @(negedge clk);
        force_ack = 0;
        @(negedge clk);
        rst_n = 1'b1;
        start = n_irl;
        seen = 0;
        repeat (5) begin @(negedge clk); seen = seen | bus.irload; end
        check("no_irload_after_rst_ack", seen, 0);
        check("irl_count_after_rst", n_irl, start);
        check("instr_after_rst", bus.instruction, 0);
        lat_lo = 0; lat_hi = 0;
        bus.halt = 1'b0;
        wait_irload("irload_after_rst");
        check("instr_restart", bus.instruction, 16'h1234);
        bus.halt = 1'b1;
        wait_idle("idle_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
